// File: rtl/pipeline_stall_ctrl_if.sv
// Control bundle between the five-stage pipeline and its freeze/flush controller.
// The pipeline side (master) presents hazard/branch/memory status and consumes freeze/flush.
interface pipeline_stall_ctrl_if;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_two_src;
    logic        id_valid;
    logic [3:0]  exe_dest;
    logic        exe_wb_en;
    logic        exe_mem_r_en;
    logic [3:0]  mem_dest;
    logic        mem_wb_en;
    logic        fwd_en;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        if_freeze;
    logic        id_freeze;
    logic        exe_freeze;
    logic        mem_freeze;
    logic        id_flush;
    logic        exe_flush;
    logic        mem_err;
    logic [15:0] stall_cycles;
    logic [7:0]  flush_count;

    modport master (
        output id_src1, id_src2, id_two_src, id_valid,
        output exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
        output fwd_en, branch_taken, mem_req, mem_ready,
        input  if_freeze, id_freeze, exe_freeze, mem_freeze,
        input  id_flush, exe_flush, mem_err, stall_cycles, flush_count
    );

    modport slave (
        input  id_src1, id_src2, id_two_src, id_valid,
        input  exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
        input  fwd_en, branch_taken, mem_req, mem_ready,
        output if_freeze, id_freeze, exe_freeze, mem_freeze,
        output id_flush, exe_flush, mem_err, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central freeze/flush controller: memory-wait stall with timeout watchdog, taken-branch
// flush and RAW/load-use hazard bubbles, plus saturating stall/flush counters.
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t      state, state_nxt;
    logic [7:0]  wcnt, wcnt_nxt;
    logic        mstall;
    logic        exe_match, mem_match, dh;
    logic        if_frz, id_frz, exe_frz, mem_frz, id_fl, exe_fl;
    logic [15:0] stall_cnt;
    logic [7:0]  flush_cnt;

    localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            wcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    state_nxt = MEM_WAIT;
                    wcnt_nxt  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_nxt = RUN;
                    wcnt_nxt  = 8'd0;
                end else if (wcnt == WCNT_LAST) begin
                    state_nxt = ERR;
                end else begin
                    wcnt_nxt  = wcnt + 8'd1;
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = RUN;
        endcase
    end

    // MEM_WAIT ignores mem_req: the MEM stage is frozen, so the access is still pending.
    assign mstall = (state == MEM_WAIT && !bus.mem_ready)
                  || (state == RUN && bus.mem_req && !bus.mem_ready)
                  || (state == ERR);

    assign exe_match = (bus.exe_dest == bus.id_src1)
                     || (bus.id_two_src && bus.exe_dest == bus.id_src2);
    assign mem_match = (bus.mem_dest == bus.id_src1)
                     || (bus.id_two_src && bus.mem_dest == bus.id_src2);

    always_comb begin
        if (bus.fwd_en)
            dh = bus.exe_wb_en && bus.exe_mem_r_en && exe_match;
        else
            dh = (bus.exe_wb_en && exe_match) || (bus.mem_wb_en && mem_match);
    end

    always_comb begin
        if_frz  = 1'b0;
        id_frz  = 1'b0;
        exe_frz = 1'b0;
        mem_frz = 1'b0;
        id_fl   = 1'b0;
        exe_fl  = 1'b0;
        if (rst) begin
            if_frz = 1'b0;
        end else if (mstall) begin
            if_frz  = 1'b1;
            id_frz  = 1'b1;
            exe_frz = 1'b1;
            mem_frz = 1'b1;
        end else if (bus.branch_taken) begin
            id_fl  = 1'b1;
            exe_fl = 1'b1;
        end else if (bus.id_valid && dh) begin
            // Hold IF/ID and inject a bubble into EXE; older stages keep moving.
            if_frz = 1'b1;
            id_frz = 1'b1;
            exe_fl = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 8'd0;
        end else begin
            if (if_frz && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (id_fl && flush_cnt != 8'hFF)
                flush_cnt <= flush_cnt + 8'd1;
        end
    end

    assign bus.if_freeze    = if_frz;
    assign bus.id_freeze    = id_frz;
    assign bus.exe_freeze   = exe_frz;
    assign bus.mem_freeze   = mem_frz;
    assign bus.id_flush     = id_fl;
    assign bus.exe_flush    = exe_fl;
    assign bus.mem_err      = (state == ERR);
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_count  = flush_cnt;

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central freeze/flush controller for the five-stage ARM pipeline. It drives the `freeze` and `flush` inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers. It resolves three cases: data hazards (load-use, or all RAW hazards when forwarding is off), taken branches from EXE, and multi-cycle external memory accesses through a request/ready handshake with a timeout watchdog. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `MEM_TIMEOUT`, 64: maximum consecutive wait cycles for one memory access before the error state; legal range 2..255.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_src1`, `id_src2` in 4: source register numbers of the instruction in ID.
- `id_two_src` in 1: `id_src2` is a real operand.
- `id_valid` in 1: ID holds a real instruction (0 = bubble).
- `exe_dest` in 4, `exe_wb_en` in 1, `exe_mem_r_en` in 1: destination, writeback and load flag of the instruction in EXE.
- `mem_dest` in 4, `mem_wb_en` in 1: destination and writeback flag of the instruction in MEM.
- `fwd_en` in 1: forwarding unit active.
- `branch_taken` in 1: EXE resolved a taken branch this cycle.
- `mem_req` in 1: MEM stage is performing a load or store.
- `mem_ready` in 1: external memory completes the access this cycle.
- `if_freeze`, `id_freeze`, `exe_freeze`, `mem_freeze` out 1: hold PC/IF-ID, ID/EXE, EXE/MEM and MEM/WB respectively.
- `id_flush`, `exe_flush` out 1: zero the IF/ID and ID/EXE registers.
- `mem_err` out 1: sticky memory timeout error.
- `stall_cycles` out 16: saturating count of cycles with `if_freeze`=1.
- `flush_count` out 8: saturating count of branch flushes.

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Wait counter `wcnt` is 8 bits.
- RUN:
  - If `mem_req` & ~`mem_ready`: go to MEM_WAIT and set `wcnt`=1.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - If `mem_ready`: go to RUN and set `wcnt`=0.
  - Else if `wcnt` == `MEM_TIMEOUT`-1: go to ERR.
  - Else increment `wcnt`.
- ERR: stays until `rst`.
- Memory stall is `mstall` = (state==MEM_WAIT & ~`mem_ready`) | (state==RUN & `mem_req` & ~`mem_ready`) | state==ERR.
  - While `mstall`: all four freezes = 1 and both flushes = 0.
  - Nothing else is evaluated.
- Branch: `branch_taken` & ~`mstall` sets `id_flush`=1 and `exe_flush`=1. No freezes are asserted.
  - A branch arriving during a memory stall is not lost. EXE is frozen, so `branch_taken` is held and the flush fires on the release cycle.
- Data hazard `dh` is evaluated only when ~`mstall` & ~`branch_taken` & `id_valid`.
  - Match is (`exe_dest`==`id_src1`) | (`id_two_src` & `exe_dest`==`id_src2`). The MEM match uses the same form with `mem_dest`.
  - With `fwd_en`=1: `dh` = `exe_wb_en` & `exe_mem_r_en` & EXE match.
  - With `fwd_en`=0: `dh` = (`exe_wb_en` & EXE match) | (`mem_wb_en` & MEM match).
  - Response: `if_freeze`=1, `id_freeze`=1, `exe_flush`=1 (bubble into EXE). `exe_freeze`, `mem_freeze` and `id_flush` stay 0.
- Priority: `mstall` > branch > `dh`.
- `mem_err` = (state==ERR).
- Counters:
  - `stall_cycles` increments on every cycle with `if_freeze`=1 and saturates at 0xFFFF.
  - `flush_count` increments on every cycle with `id_flush`=1 and saturates at 0xFF.
- Reset: state=RUN, `wcnt`=0, `stall_cycles`=0, `flush_count`=0, `mem_err`=0. While `rst`=1, all freeze/flush outputs are forced to 0.

## Timing
- All freeze/flush outputs are combinational from the inputs and current state, valid in the same cycle. There is no added latency.
- Memory access, single-cycle case (`mem_ready`=1 together with `mem_req`): no stall.
- Memory access, N-cycle case (`mem_ready` first high on cycle N): freezes are high for cycles 1..N-1 and low on cycle N, when the pipeline advances.
- Timeout: with `mem_ready` never asserted, ERR is entered at the edge after the `MEM_TIMEOUT`-th wait cycle. `mem_err` rises on the following cycle and freezes stay high forever.
- Reset mid-MEM_WAIT: the next cycle is RUN with freezes low. Only `mem_req` re-evaluation can re-stall.
- A load-use hazard causes exactly one bubble when `fwd_en`=1. When `fwd_en`=0 a RAW hazard lasts until the writer leaves MEM, up to two bubbles.

## Test plan
- Load-use: EXE holds a load with `exe_dest`=3 and `exe_wb_en`=1; ID has `id_src1`=3, `fwd_en`=1. Required: `if_freeze`=`id_freeze`=`exe_flush`=1 for 1 cycle, and `stall_cycles` becomes 1.
- No-forward RAW: `fwd_en`=0, `mem_dest`=5, `mem_wb_en`=1, `id_two_src`=1, `id_src2`=5. Required: hazard response. With `id_two_src`=0 there is no stall.
- Branch: `branch_taken`=1 together with a matching hazard. Required: `id_flush`=`exe_flush`=1, `if_freeze`=0, `flush_count`=1.
- Memory wait: `mem_req`=1 with `mem_ready` high on the 4th cycle and `branch_taken` held high. Required: all freezes are 1 for 3 cycles, then on the release cycle the freezes are 0 and both flushes are 1.
- Timeout: `MEM_TIMEOUT`=4 and `mem_ready` held at 0. Required: `mem_err`=1 from cycle 5 onward and the freezes stay 1. Asserting `rst` for one cycle returns the block to RUN with `mem_err`=0 and the counters at 0.
- Saturation: force 65540 freeze cycles. Required: `stall_cycles` holds 0xFFFF.
